axis_meta_demux: RTL and testbench

//  Per-packet AXI-Stream demultiplexer that sits after the vitis_net_p4 pipeline output.
//  The destination is taken from user_metadata on the first beat of each packet.
//  The whole packet is then steered to one of NUM_CH egress channels, with one output register stage.

---
 rtl/axis_meta_demux.sv | 202 ++++++++++++++++++++
 tb/tb_axis_meta_demux.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_meta_demux.sv
// axis_meta_demux: per-packet AXI-Stream demultiplexer driven by user_metadata.
// The destination is read from the first beat's metadata. The whole packet is then
// steered to one of NUM_CH channels through a single output register stage.
// Packets with no metadata or an out-of-range destination are consumed and dropped.
// Optional build macro: AXIS_META_DEMUX_STATS_EN adds the per-channel packet
// counters and the drop counter (stat_pkt_cnt, stat_drop_cnt).
module axis_meta_demux #(
  parameter int TDATA_NUM_BYTES      = 64,
  parameter int USER_META_DATA_WIDTH = 9,
  parameter int NUM_CH               = 4,
  parameter int DEST_LSB             = 0,
  parameter int DEST_WIDTH           = 4
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_aresetn,
  input  logic [USER_META_DATA_WIDTH-1:0]   user_metadata_in,
  input  logic                              user_metadata_in_valid,
  input  logic [TDATA_NUM_BYTES*8-1:0]      s_axis_tdata,
  input  logic [TDATA_NUM_BYTES-1:0]        s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [TDATA_NUM_BYTES*8-1:0]      m_axis_tdata,
  output logic [TDATA_NUM_BYTES-1:0]        m_axis_tkeep,
  output logic [NUM_CH-1:0]                 m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic [NUM_CH-1:0]                 m_axis_tready,
  output logic [USER_META_DATA_WIDTH-1:0]   user_metadata_out,
  output logic                              user_metadata_out_valid,
`ifdef AXIS_META_DEMUX_STATS_EN
  output logic [NUM_CH*32-1:0]              stat_pkt_cnt,
  output logic [31:0]                       stat_drop_cnt,
`endif
  output logic                              drop_pulse
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW    = TDATA_NUM_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Registered copy of reset so tready stays low for the whole reset cycle
  logic aresetn_q_reg;

  // Output register stage (one beat deep)
  logic                            out_full_reg, out_full_next;
  logic [DW-1:0]                   out_data_reg, out_data_next;
  logic [TDATA_NUM_BYTES-1:0]      out_keep_reg, out_keep_next;
  logic                            out_last_reg, out_last_next;
  logic [USER_META_DATA_WIDTH-1:0] out_meta_reg, out_meta_next;
  logic                            out_meta_valid_reg, out_meta_valid_next;
  logic [SEL_W-1:0]                sel_reg, sel_next;
  logic                            drop_pulse_reg, drop_pulse_next;

  logic [DEST_WIDTH-1:0] dest;
  logic [31:0]           dest_ext;
  logic                  meta_ok;
  logic                  sel_ready;
  logic                  in_hs;
  logic                  unload;
  logic                  load;
  logic                  load_first;
  logic                  drop_event;

  assign dest      = user_metadata_in[DEST_LSB +: DEST_WIDTH];
  assign dest_ext  = 32'(dest);
  assign meta_ok   = user_metadata_in_valid & (dest_ext < 32'(NUM_CH));
  // sel only ever holds an in-range channel, so this index is always valid
  assign sel_ready = m_axis_tready[sel_reg];
  assign unload    = out_full_reg & sel_ready;

  // Accept when the register is empty, drains this cycle, or the packet is being discarded
  assign s_axis_tready = aresetn_q_reg & (~out_full_reg | sel_ready | (state_reg == ST_DROP));
  assign in_hs         = s_axis_tvalid & s_axis_tready;

  // FSM state register
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and beat routing decisions
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_first = 1'b0;
    drop_event = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_hs) begin
          if (meta_ok) begin
            load       = 1'b1;
            load_first = 1'b1;
            if (!s_axis_tlast) state_next = ST_FWD;
          end else if (s_axis_tlast) begin
            drop_event = 1'b1;
          end else begin
            state_next = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (in_hs) begin
          load = 1'b1;
          if (s_axis_tlast) state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (in_hs && s_axis_tlast) begin
          drop_event = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output register next values: load replaces, unload empties, otherwise hold
  always_comb begin
    out_full_next       = load | (out_full_reg & ~unload);
    out_data_next       = load ? s_axis_tdata : out_data_reg;
    out_keep_next       = load ? s_axis_tkeep : out_keep_reg;
    out_last_next       = load ? s_axis_tlast : out_last_reg;
    out_meta_valid_next = load ? load_first : (unload ? 1'b0 : out_meta_valid_reg);
    out_meta_next       = load_first ? user_metadata_in : out_meta_reg;
    sel_next            = load_first ? dest_ext[SEL_W-1:0] : sel_reg;
    drop_pulse_next     = drop_event;
  end

  // Output register stage and reset tracking
  always_ff @(posedge s_axis_aclk) begin
    aresetn_q_reg <= s_axis_aresetn;
    if (!s_axis_aresetn) begin
      out_full_reg       <= 1'b0;
      out_data_reg       <= '0;
      out_keep_reg       <= '0;
      out_last_reg       <= 1'b0;
      out_meta_reg       <= '0;
      out_meta_valid_reg <= 1'b0;
      sel_reg            <= '0;
      drop_pulse_reg     <= 1'b0;
    end else begin
      out_full_reg       <= out_full_next;
      out_data_reg       <= out_data_next;
      out_keep_reg       <= out_keep_next;
      out_last_reg       <= out_last_next;
      out_meta_reg       <= out_meta_next;
      out_meta_valid_reg <= out_meta_valid_next;
      sel_reg            <= sel_next;
      drop_pulse_reg     <= drop_pulse_next;
    end
  end

  // One-hot channel valid decoded from the held selection
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_valid
    assign m_axis_tvalid[gi] = out_full_reg & (sel_reg == SEL_W'(gi));
  end

  assign m_axis_tdata            = out_data_reg;
  assign m_axis_tkeep            = out_keep_reg;
  assign m_axis_tlast            = out_last_reg;
  assign user_metadata_out       = out_meta_reg;
  assign user_metadata_out_valid = out_meta_valid_reg;
  assign drop_pulse              = drop_pulse_reg;

`ifdef AXIS_META_DEMUX_STATS_EN
  logic [31:0] pkt_cnt_reg [NUM_CH];
  logic [31:0] drop_cnt_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stats
    // Count packet ends leaving on this channel; wraps naturally
    always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
        pkt_cnt_reg[gi] <= '0;
      end else if (unload && out_last_reg && (sel_reg == SEL_W'(gi))) begin
        pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + 32'd1;
      end
    end
    assign stat_pkt_cnt[gi*32 +: 32] = pkt_cnt_reg[gi];
  end

  // Count drop pulses; wraps naturally
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      drop_cnt_reg <= '0;
    end else if (drop_pulse_reg) begin
      drop_cnt_reg <= drop_cnt_reg + 32'd1;
    end
  end
  assign stat_drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_axis_meta_demux.sv
// Testbench for axis_meta_demux: directed scenarios plus randomized packets,
// checked every cycle against a packet-level reference model.
module tb_axis_meta_demux;

  localparam int NB  = 64;
  localparam int DW  = NB * 8;
  localparam int MW  = 9;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              s_axis_aresetn = 1'b0;
  logic [MW-1:0]     user_metadata_in = '0;
  logic              user_metadata_in_valid = 1'b0;
  logic [DW-1:0]     s_axis_tdata = '0;
  logic [NB-1:0]     s_axis_tkeep = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [NB-1:0]     m_axis_tkeep;
  logic [NCH-1:0]    m_axis_tvalid;
  logic              m_axis_tlast;
  logic [NCH-1:0]    m_axis_tready = '0;
  logic [MW-1:0]     user_metadata_out;
  logic              user_metadata_out_valid;
  logic              drop_pulse;
`ifdef AXIS_META_DEMUX_STATS_EN
  logic [NCH*32-1:0] stat_pkt_cnt;
  logic [31:0]       stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  axis_meta_demux #(
    .TDATA_NUM_BYTES(NB), .USER_META_DATA_WIDTH(MW), .NUM_CH(NCH),
    .DEST_LSB(0), .DEST_WIDTH(4)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(s_axis_aresetn),
    .user_metadata_in(user_metadata_in),
    .user_metadata_in_valid(user_metadata_in_valid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .user_metadata_out(user_metadata_out),
    .user_metadata_out_valid(user_metadata_out_valid),
`ifdef AXIS_META_DEMUX_STATS_EN
    .stat_pkt_cnt(stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt),
`endif
    .drop_pulse(drop_pulse)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
    logic          first;
    logic          mv;
    logic [MW-1:0] meta;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
    logic          first;
    logic [MW-1:0] meta;
    int            ch;
  } exp_t;

  beat_t src_q[$];   // beats still to be offered
  exp_t  exp_q[$];   // beats accepted for forwarding, not yet delivered

  int checks = 0;
  int errors = 0;

  // Model state
  bit             holding = 0;
  bit             dropping = 0;
  bit             cur_ok = 0;
  logic [MW-1:0]  cur_meta = '0;
  int             cur_ch = 0;
  bit             drop_pend = 0;
  int             drop_exp_total = 0;
  int             drop_obs_total = 0;
  int             drop_since_rst = 0;
  int             pkt_since_rst [NCH];
  bit             rst_req = 1;
  logic [NCH-1:0] force_low = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic add_pkt(input logic mv, input logic [MW-1:0] meta, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = rand_data();
      b.keep  = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
      b.last  = (i == len - 1);
      b.first = (i == 0);
      b.mv    = (i == 0) ? mv : 1'($urandom);
      b.meta  = (i == 0) ? meta : MW'($urandom);
      src_q.push_back(b);
    end
    $display("pkt queued: meta_valid=%0d meta=%03h dest=%0d beats=%0d", mv, meta, meta[3:0], len);
  endtask

  // Apply the packet rules to one accepted ingress beat
  task automatic accept(input beat_t b);
    exp_t e;
    if (b.first) begin
      cur_ok   = b.mv && (int'(b.meta[3:0]) < NCH);
      cur_meta = b.meta;
      cur_ch   = int'(b.meta[3:0]);
    end
    if (cur_ok) begin
      e.data = b.data; e.keep = b.keep; e.last = b.last;
      e.first = b.first; e.meta = cur_meta; e.ch = cur_ch;
      exp_q.push_back(e);
      dropping = 0;
    end else begin
      dropping = !b.last;
      if (b.last) begin
        drop_pend = 1;
        drop_exp_total++;
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later
  task automatic cycle(input int vpct, input int rpct);
    logic sampled_rstn;
    bit   exp_drop;
    bit   exp_tready;
    logic [NCH-1:0] exp_valid;
    @(negedge clk);
    sampled_rstn   = s_axis_aresetn;
    s_axis_aresetn = !rst_req;
    if (rst_req) begin
      s_axis_tvalid = 1'b0;
      holding = 0;
      while (src_q.size() > 0 && !src_q[0].first) void'(src_q.pop_front());
    end else if (!holding) begin
      if (src_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
        s_axis_tvalid          = 1'b1;
        s_axis_tdata           = src_q[0].data;
        s_axis_tkeep           = src_q[0].keep;
        s_axis_tlast           = src_q[0].last;
        user_metadata_in_valid = src_q[0].mv;
        user_metadata_in       = src_q[0].meta;
        holding = 1;
      end else begin
        s_axis_tvalid          = 1'b0;
        s_axis_tdata           = rand_data();
        s_axis_tlast           = 1'($urandom);
        user_metadata_in_valid = 1'($urandom);
        user_metadata_in       = MW'($urandom);
      end
    end
    for (int c = 0; c < NCH; c++)
      m_axis_tready[c] = ($urandom_range(0, 99) < rpct) && !force_low[c];
    #1;
    exp_drop  = drop_pend;
    drop_pend = 0;
    if (!sampled_rstn) begin
      exp_q.delete();
      dropping = 0; cur_ok = 0; exp_drop = 0;
      drop_since_rst = 0;
      for (int c = 0; c < NCH; c++) pkt_since_rst[c] = 0;
    end
    exp_valid = (exp_q.size() > 0) ? NCH'(1 << exp_q[0].ch) : '0;
    check("tvalid", m_axis_tvalid, exp_valid);
    if (!sampled_rstn) begin
      exp_tready = 0;
      check("rst_tdata", m_axis_tdata, '0);
      check("rst_tkeep", m_axis_tkeep, '0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_meta", user_metadata_out, '0);
      check("rst_meta_valid", user_metadata_out_valid, 0);
      check("rst_drop", drop_pulse, 0);
      check("rst_tready", s_axis_tready, 0);
    end else begin
      exp_tready = (exp_q.size() == 0) || dropping || m_axis_tready[exp_q[0].ch];
      check("tready", s_axis_tready, exp_tready);
      check("drop_pulse", drop_pulse, exp_drop);
      if (drop_pulse) begin
        drop_obs_total++;
        drop_since_rst++;
      end
      check("meta_valid", user_metadata_out_valid, (exp_q.size() > 0) ? exp_q[0].first : 1'b0);
      if (exp_q.size() > 0) begin
        check("tdata", m_axis_tdata, exp_q[0].data);
        check("tkeep", m_axis_tkeep, exp_q[0].keep);
        check("tlast", m_axis_tlast, exp_q[0].last);
        check("meta", user_metadata_out, exp_q[0].meta);
      end
    end
    // Egress handshake retires the model's front beat
    if (exp_q.size() > 0 && m_axis_tready[exp_q[0].ch]) begin
      $display("egress ch%0d last=%0d first=%0d keep=%016h", exp_q[0].ch, exp_q[0].last,
               exp_q[0].first, exp_q[0].keep);
      if (exp_q[0].last) pkt_since_rst[exp_q[0].ch]++;
      void'(exp_q.pop_front());
    end
    // Ingress handshake feeds the model
    if (s_axis_tvalid && exp_tready && holding) begin
      $display("ingress first=%0d last=%0d mv=%0d meta=%03h", src_q[0].first, src_q[0].last,
               src_q[0].mv, src_q[0].meta);
      accept(src_q.pop_front());
      holding = 0;
    end
  endtask

  task automatic drain(input int vpct, input int rpct, input int max_cycles);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || holding) && n < max_cycles) begin
      cycle(vpct, rpct);
      n++;
    end
    check("drain_done", src_q.size() + exp_q.size(), 0);
    repeat (3) cycle(0, 100);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) pkt_since_rst[c] = 0;
    rst_req = 1;
    repeat (3) cycle(0, 100);
    rst_req = 0;
    cycle(0, 100);

    // Single-beat packet to channel 2
    add_pkt(1, 9'h002, 1);
    drain(100, 100, 50);

    // Three beats to channel 1 with a 5+ cycle stall mid-packet
    force_low = 4'b0010;
    add_pkt(1, 9'h001, 3);
    repeat (8) cycle(100, 100);
    force_low = '0;
    drain(100, 100, 50);

    // Out-of-range destination: consumed and dropped
    add_pkt(1, 9'h007, 2);
    drain(100, 100, 50);

    // Missing metadata, then a normal packet to channel 0
    add_pkt(0, 9'h000, 2);
    add_pkt(1, 9'h000, 2);
    drain(100, 100, 50);

    // Back-to-back packets, channel 0 then channel 3
    add_pkt(1, 9'h000, 3);
    add_pkt(1, 9'h003, 3);
    drain(100, 100, 50);

    // Reset in the middle of a forwarded packet, then a packet to channel 1
    add_pkt(1, 9'h102, 6);
    repeat (3) cycle(100, 100);
    rst_req = 1;
    cycle(100, 100);
    rst_req = 0;
    cycle(0, 100);
    add_pkt(1, 9'h001, 2);
    drain(100, 100, 50);

    // Randomized traffic with random valid/ready gaps
    for (int p = 0; p < 60; p++) begin
      logic [MW-1:0] m;
      m = {5'($urandom), 4'($urandom_range(0, 5))};
      add_pkt($urandom_range(0, 99) < 85, m, $urandom_range(1, 5));
    end
    drain(60, 60, 20000);

    // Randomized traffic at full rate
    for (int p = 0; p < 20; p++) begin
      logic [MW-1:0] m;
      m = {5'($urandom), 4'($urandom_range(0, 4))};
      add_pkt($urandom_range(0, 99) < 90, m, $urandom_range(1, 4));
    end
    drain(100, 100, 5000);

    check("drop_total", drop_obs_total, drop_exp_total);
`ifdef AXIS_META_DEMUX_STATS_EN
    check("stat_drop_cnt", stat_drop_cnt, drop_since_rst);
    for (int c = 0; c < NCH; c++)
      check("stat_pkt_cnt", stat_pkt_cnt[c*32 +: 32], pkt_since_rst[c]);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
